// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target predictor.
// Optional feature macro: BP_TAG_CHECK_EN (adds a per-entry tag and tag-qualified hits).
package bp_pkg;

   // Entry layout. The predictor and table parameters must match these widths.
   localparam int BP_PC_W    = 16;
   localparam int BP_INDEX_W = 6;
   localparam int BP_CTR_W   = 2;
   localparam int BP_TAG_W   = BP_PC_W - BP_INDEX_W;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_e;

   typedef struct packed {
      logic                valid;
      logic [BP_CTR_W-1:0] ctr;
      logic [BP_PC_W-1:0]  target;
`ifdef BP_TAG_CHECK_EN
      logic [BP_TAG_W-1:0] tag;
`endif
   } bp_entry_t;

   // Weakly not taken: the largest value whose MSB is clear.
   function automatic int bp_wnt(input int ctr_w);
      return (1 << (ctr_w - 1)) - 1;
   endfunction

   // Weakly taken: the smallest value whose MSB is set.
   function automatic int bp_wt(input int ctr_w);
      return 1 << (ctr_w - 1);
   endfunction

   // Saturation ceiling of the direction counter.
   function automatic int bp_max(input int ctr_w);
      return (1 << ctr_w) - 1;
   endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor entry storage: one combinational read port, one synchronous write port.
// Optional feature macro: BP_TAG_CHECK_EN (widens bp_entry_t with a tag field).
module bp_table
   import bp_pkg::*;
#(
   parameter int INDEX_W = BP_INDEX_W,
   parameter int PC_W    = BP_PC_W,
   parameter int CTR_W   = BP_CTR_W
) (
   input  logic               clk,
   input  logic [INDEX_W-1:0] rd_idx_i,
   output bp_entry_t          rd_entry_o,
   input  logic               wr_en_i,
   input  logic [INDEX_W-1:0] wr_idx_i,
   input  bp_entry_t          wr_entry_i
);

   localparam int ENTRIES = 1 << INDEX_W;

   // The entry layout lives in bp_pkg; refuse to elaborate against a different one.
   if (PC_W != BP_PC_W || INDEX_W != BP_INDEX_W || CTR_W != BP_CTR_W || CTR_W < 2) begin : g_bad_layout
      $error("bp_table: parameters do not match bp_entry_t in bp_pkg");
   end

   // NOTE: the array has no reset; the owner clears it with a sweep and masks reads until then.
   bp_entry_t mem_q [ENTRIES];

   // Single write port, committed on the clock edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (wr_en_i) mem_q[wr_idx_i] <= wr_entry_i;
   end

   assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Branch target predictor: same-cycle taken/target guess for fetch, trained by execute.
// A table-clear sweep runs after reset; ready rises when it completes.
// Optional feature macro: BP_TAG_CHECK_EN (hits require a matching upper-PC tag).
module branch_predictor
   import bp_pkg::*;
#(
   parameter int PC_W    = 16,
   parameter int INDEX_W = 6,
   parameter int CTR_W   = 2,
   parameter int STAT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   pred_pc,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              upd_mispredict,
   output logic              ready,
   output logic [STAT_W-1:0] mispredict_count
);

   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(bp_wnt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(bp_wt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(bp_max(CTR_W));

   bp_state_e          state_q, state_d;
   logic [INDEX_W-1:0] sweep_q, sweep_d;
   logic [STAT_W-1:0]  stat_q, stat_d;

   bp_entry_t          pred_entry, upd_entry, wr_entry;
   logic               wr_en, tbl_we;
   logic [INDEX_W-1:0] wr_idx;
   logic               pred_hit, upd_hit;
   logic               unused_bits;

   // Two identical banks give prediction and update each a private read port.
   assign tbl_we = wr_en && !rst;

   bp_table #(.INDEX_W(INDEX_W), .PC_W(PC_W), .CTR_W(CTR_W)) u_pred_bank (
      .clk        (clk),
      .rd_idx_i   (pred_pc[INDEX_W-1:0]),
      .rd_entry_o (pred_entry),
      .wr_en_i    (tbl_we),
      .wr_idx_i   (wr_idx),
      .wr_entry_i (wr_entry)
   );

   bp_table #(.INDEX_W(INDEX_W), .PC_W(PC_W), .CTR_W(CTR_W)) u_upd_bank (
      .clk        (clk),
      .rd_idx_i   (upd_pc[INDEX_W-1:0]),
      .rd_entry_o (upd_entry),
      .wr_en_i    (tbl_we),
      .wr_idx_i   (wr_idx),
      .wr_entry_i (wr_entry)
   );

`ifdef BP_TAG_CHECK_EN
   assign pred_hit    = pred_entry.valid && (pred_entry.tag == pred_pc[PC_W-1:INDEX_W]);
   assign upd_hit     = upd_entry.valid && (upd_entry.tag == upd_pc[PC_W-1:INDEX_W]);
   assign unused_bits = ^pred_entry.ctr[CTR_W-2:0];
`else
   assign pred_hit    = pred_entry.valid;
   assign upd_hit     = upd_entry.valid;
   assign unused_bits = ^{pred_entry.ctr[CTR_W-2:0], pred_pc[PC_W-1:INDEX_W], upd_pc[PC_W-1:INDEX_W]};
`endif

   // Table contents are only trustworthy once the sweep has finished.
   assign ready            = (state_q == RUN);
   assign pred_taken       = ready && pred_hit && pred_entry.ctr[CTR_W-1];
   assign pred_target      = pred_taken ? pred_entry.target : '0;
   assign mispredict_count = stat_q;

   // State, sweep and statistics registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         sweep_q <= '0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
         stat_q  <= stat_d;
      end
   end

   // Next state, table write request and mispredict counter.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d  = state_q;
      sweep_d  = sweep_q;
      stat_d   = stat_q;
      wr_en    = 1'b0;
      wr_idx   = upd_pc[INDEX_W-1:0];
      wr_entry = upd_entry;

      case (state_q)
         INIT: begin
            wr_en        = 1'b1;
            wr_idx       = sweep_q;
            wr_entry     = '0;
            wr_entry.ctr = CTR_WNT;
            sweep_d      = sweep_q + 1'b1;
            if (sweep_q == '1) state_d = RUN;
         end
         RUN: begin
            if (upd_valid) begin
               if (upd_hit) begin
                  wr_en = 1'b1;
                  if (upd_taken) begin
                     if (upd_entry.ctr != CTR_MAX) wr_entry.ctr = upd_entry.ctr + 1'b1;
                     wr_entry.target = upd_target;
                  end else if (upd_entry.ctr != '0) begin
                     wr_entry.ctr = upd_entry.ctr - 1'b1;
                  end
               end else if (upd_taken) begin
                  wr_en           = 1'b1;
                  wr_entry.valid  = 1'b1;
                  wr_entry.ctr    = CTR_WT;
                  wr_entry.target = upd_target;
`ifdef BP_TAG_CHECK_EN
                  wr_entry.tag    = upd_pc[PC_W-1:INDEX_W];
`endif
               end
               if (upd_mispredict && stat_q != '1) stat_d = stat_q + 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: default instance plus a STAT_W=2 instance.
// Expectations follow BP_TAG_CHECK_EN when the build defines it.
`timescale 1ns/1ps
module tb_branch_predictor;

   localparam int PC_W    = 16;
   localparam int INDEX_W = 6;
   localparam int CTR_W   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [PC_W-1:0] pred_pc;
   logic            upd_valid;
   logic [PC_W-1:0] upd_pc;
   logic            upd_taken;
   logic [PC_W-1:0] upd_target;
   logic            upd_mispredict;

   logic            pred_taken, ready;
   logic [PC_W-1:0] pred_target;
   logic [15:0]     mispredict_count;
   logic            pred_taken_s2, ready_s2;
   logic [PC_W-1:0] pred_target_s2;
   logic [1:0]      mispredict_count_s2;

   always #5 clk = ~clk;

   branch_predictor #(.PC_W(PC_W), .INDEX_W(INDEX_W), .CTR_W(CTR_W), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .ready(ready), .mispredict_count(mispredict_count)
   );

   branch_predictor #(.PC_W(PC_W), .INDEX_W(INDEX_W), .CTR_W(CTR_W), .STAT_W(2)) dut_s2 (
      .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken_s2), .pred_target(pred_target_s2),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_mispredict(upd_mispredict), .ready(ready_s2), .mispredict_count(mispredict_count_s2)
   );

   typedef struct {
      string           name;
      logic [PC_W-1:0] pred_pc;
      logic            upd_valid;
      logic [PC_W-1:0] upd_pc;
      logic            upd_taken;
      logic [PC_W-1:0] upd_target;
      logic            exp_taken;
      logic [PC_W-1:0] exp_target;
   } vec_t;

   typedef struct {
      string           name;
      logic            exp_taken;
      logic [PC_W-1:0] exp_target;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic void add(input string n, input int ppc, input int uv, input int upc,
                               input int ut, input int utg, input int et, input int etg);
      vec_t v;
      v.name       = n;
      v.pred_pc    = PC_W'(ppc);
      v.upd_valid  = (uv != 0);
      v.upd_pc     = PC_W'(upc);
      v.upd_taken  = (ut != 0);
      v.upd_target = PC_W'(utg);
      v.exp_taken  = (et != 0);
      v.exp_target = PC_W'(etg);
      vecs.push_back(v);
   endfunction

   task automatic idle_upd();
      upd_valid      = 1'b0;
      upd_pc         = '0;
      upd_taken      = 1'b0;
      upd_target     = '0;
      upd_mispredict = 1'b0;
   endtask

   // One cycle: inputs already driven; sample at negedge, then move to just after the next posedge.
   task automatic step_to_next();
      @(posedge clk);
      #1;
   endtask

   // Observe the full sweep, optionally with mispredicting taken updates that must be dropped.
   task automatic watch_init(input string tag, input bit with_upd);
      for (int i = 1; i <= 64; i++) begin
         pred_pc = (i % 2 == 0) ? 16'h0010 : 16'h0020;
         if (with_upd) begin
            upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1;
            upd_target = 16'h0abc; upd_mispredict = 1'b1;
         end
         @(negedge clk);
         check($sformatf("%s ready low c%0d", tag, i), 32'(ready), 32'd0);
         check($sformatf("%s pred low c%0d", tag, i), 32'(pred_taken), 32'd0);
         step_to_next();
      end
      idle_upd();
      @(negedge clk);
      check({tag, " ready high c65"}, 32'(ready), 32'd1);
      check({tag, " ready_s2 high c65"}, 32'(ready_s2), 32'd1);
      step_to_next();
   endtask

   // Every index must read back as not-taken after a sweep.
   task automatic check_cleared(input string tag);
      for (int i = 0; i < 64; i++) begin
         pred_pc = PC_W'(i) | (PC_W'($urandom_range(0, 1023)) << INDEX_W);
         @(negedge clk);
         check($sformatf("%s clear taken idx%0d", tag, i), 32'(pred_taken), 32'd0);
         check($sformatf("%s clear target idx%0d", tag, i), 32'(pred_target), 32'd0);
         step_to_next();
      end
   endtask

   task automatic mp_pulse(input bit valid);
      upd_valid = valid; upd_pc = 16'h0030; upd_taken = 1'b0;
      upd_target = '0; upd_mispredict = 1'b1;
      step_to_next();
      idle_upd();
   endtask

   task automatic check_counts(input string tag, input int exp16, input int exp2);
      @(negedge clk);
      check({tag, " count"}, 32'(mispredict_count), 32'(exp16));
      check({tag, " count_s2"}, 32'(mispredict_count_s2), 32'(exp2));
      step_to_next();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish within 500us");
      $fatal(1);
   end

   initial begin
      exp_t e;

      // name, pred_pc, upd_valid, upd_pc, upd_taken, upd_target, exp_taken, exp_target
      add("idle_miss",  'h0010, 0, 'h0000, 0, 'h0000, 0, 'h0000);
      add("alloc_same", 'h0010, 1, 'h0010, 1, 'h0004, 0, 'h0000);
      add("alloc_seen", 'h0010, 0, 'h0000, 0, 'h0000, 1, 'h0004);
`ifdef BP_TAG_CHECK_EN
      add("alias_read", 'h0050, 0, 'h0000, 0, 'h0000, 0, 'h0000);
`else
      add("alias_read", 'h0050, 0, 'h0000, 0, 'h0000, 1, 'h0004);
`endif
      add("nt_1",       'h0010, 1, 'h0010, 0, 'h0000, 1, 'h0004);
      add("nt_2",       'h0010, 1, 'h0010, 0, 'h0000, 0, 'h0000);
      add("nt_floor",   'h0010, 1, 'h0010, 0, 'h0000, 0, 'h0000);
      add("tk_1",       'h0010, 1, 'h0010, 1, 'h0004, 0, 'h0000);
      add("tk_2",       'h0010, 1, 'h0010, 1, 'h0006, 0, 'h0000);
      add("retaken",    'h0010, 0, 'h0000, 0, 'h0000, 1, 'h0006);
      add("same_cyc",   'h0020, 1, 'h0020, 1, 'h1234, 0, 'h0000);
      add("next_cyc",   'h0020, 0, 'h0000, 0, 'h0000, 1, 'h1234);
      add("sat_a",      'h0020, 1, 'h0020, 1, 'h1234, 1, 'h1234);
      add("sat_b",      'h0020, 1, 'h0020, 1, 'h1234, 1, 'h1234);
      add("dec_a",      'h0020, 1, 'h0020, 0, 'h0000, 1, 'h1234);
      add("dec_b",      'h0020, 1, 'h0020, 0, 'h0000, 1, 'h1234);
      add("dec_c",      'h0020, 0, 'h0000, 0, 'h0000, 0, 'h0000);
      add("miss_nt",    'h0030, 1, 'h0030, 0, 'h0777, 0, 'h0000);
      add("miss_nt_chk",'h0030, 0, 'h0000, 0, 'h0000, 0, 'h0000);
`ifdef BP_TAG_CHECK_EN
      add("alias_upd",  'h0050, 1, 'h0050, 1, 'h0100, 0, 'h0000);
      add("alias_new",  'h0050, 0, 'h0000, 0, 'h0000, 1, 'h0100);
      add("alias_old",  'h0010, 0, 'h0000, 0, 'h0000, 0, 'h0000);
`else
      add("alias_upd",  'h0050, 1, 'h0050, 1, 'h0100, 1, 'h0006);
      add("alias_new",  'h0050, 0, 'h0000, 0, 'h0000, 1, 'h0100);
      add("alias_old",  'h0010, 0, 'h0000, 0, 'h0000, 1, 'h0100);
`endif

      rst = 1'b1;
      pred_pc = '0;
      idle_upd();
      step_to_next();
      @(negedge clk);
      check("reset ready", 32'(ready), 32'd0);
      check("reset pred_taken", 32'(pred_taken), 32'd0);
      check("reset pred_target", 32'(pred_target), 32'd0);
      check("reset count", 32'(mispredict_count), 32'd0);
      step_to_next();
      rst = 1'b0;

      watch_init("boot", 1'b0);
      check_cleared("boot");

      foreach (vecs[i]) begin
         pred_pc    = vecs[i].pred_pc;
         upd_valid  = vecs[i].upd_valid;
         upd_pc     = vecs[i].upd_pc;
         upd_taken  = vecs[i].upd_taken;
         upd_target = vecs[i].upd_target;
         upd_mispredict = 1'b0;
         sb.push_back('{vecs[i].name, vecs[i].exp_taken, vecs[i].exp_target});
         @(negedge clk);
         e = sb.pop_front();
         check({e.name, " taken"}, 32'(pred_taken), 32'(e.exp_taken));
         check({e.name, " target"}, 32'(pred_target), 32'(e.exp_target));
         check({e.name, " taken_s2"}, 32'(pred_taken_s2), 32'(e.exp_taken));
         step_to_next();
      end
      idle_upd();
      check_counts("no_mp", 0, 0);

      for (int i = 0; i < 3; i++) mp_pulse(1'b1);
      check_counts("mp3", 3, 3);
      mp_pulse(1'b0);
      check_counts("mp_novalid", 3, 3);
      for (int i = 0; i < 2; i++) mp_pulse(1'b1);
      check_counts("mp5_sat", 5, 3);

      // Reset while running, interrupt the sweep at index 30, then let it restart.
      pred_pc = 16'h0020;
      rst = 1'b1;
      step_to_next();
      rst = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         upd_valid = 1'b1; upd_pc = 16'h0010; upd_taken = 1'b1;
         upd_target = 16'h0abc; upd_mispredict = 1'b1;
         @(negedge clk);
         check($sformatf("sweep30 ready low c%0d", i), 32'(ready), 32'd0);
         step_to_next();
      end
      rst = 1'b1;
      step_to_next();
      rst = 1'b0;
      watch_init("restart", 1'b1);
      check_counts("restart", 0, 0);
      check_cleared("restart");

      for (int i = 0; i < 3; i++) mp_pulse(1'b1);
      check_counts("post_mp3", 3, 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
